// File: rtl/gpio_bus_bridge.sv
// gpio_bus_bridge: translates single-outstanding CPU bus requests into
// register-IP accesses on a 256-byte GPIO window. Partial writes become a
// read-modify-write. Illegal, misaligned or read-only-violating accesses
// complete at once with an error and never touch the register IP.
module gpio_bus_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        bus_valid,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic [3:0]  bus_wstrb,
    output logic        bus_ready,
    output logic [31:0] bus_rdata,
    output logic        bus_err,
    output logic        gpio_en,
    output logic        gpio_wr,
    output logic [7:0]  gpio_addr_offset,
    output logic [31:0] gpio_data_in,
    input  logic [31:0] gpio_data_out
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_ISSUE   = 3'd1,
        RD_CAPTURE = 3'd2,
        WR_ISSUE   = 3'd3,
        RESP       = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_is_rd;
    logic        r_err;
    logic [7:0]  r_off;
    logic [31:0] r_hold;
    logic [31:0] r_din;

    logic        w_hit;
    logic        w_accept;
    logic [7:0]  w_off;
    logic        w_is_rd;
    logic        w_full;
    logic        w_bad;
    logic [31:0] w_merged;

    // Request decode on the live bus; only meaningful in IDLE.
    always_comb begin
        w_hit    = bus_valid && (bus_addr[31:8] == BASE_ADDR[31:8]);
        w_accept = (r_state == IDLE) && w_hit;
        w_off    = bus_addr[7:0];
        w_is_rd  = (bus_wstrb == 4'h0);
        w_full   = (bus_wstrb == 4'hF);
        // Only 0x00/0x04/0x08 exist (which also rules out misalignment);
        // 0x08 is the input register and cannot be written.
        w_bad    = !((w_off == 8'h00) || (w_off == 8'h04) || (w_off == 8'h08))
                   || ((w_off == 8'h08) && !w_is_rd);
    end

    // Byte merge for read-modify-write: fresh read data fills unstrobed lanes.
    always_comb begin
        w_merged = 32'h0;
        for (int i = 0; i < 4; i++) begin
            w_merged[8*i +: 8] = r_wstrb[i] ? r_wdata[8*i +: 8] : gpio_data_out[8*i +: 8];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_bad)        w_next = RESP;
                    else if (w_is_rd) w_next = RD_ISSUE;
                    else if (w_full)  w_next = WR_ISSUE;
                    else              w_next = RD_ISSUE;
                end
            end
            RD_ISSUE:   w_next = RD_CAPTURE;
            RD_CAPTURE: w_next = r_is_rd ? RESP : WR_ISSUE;
            WR_ISSUE:   w_next = RESP;
            RESP:       w_next = IDLE;
            default:    w_next = IDLE;
        endcase
    end

    // Request capture at acceptance; the bus may change freely afterwards.
    // The offset register only moves for legal accesses so it stays put
    // across error responses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wdata <= 32'h0;
            r_wstrb <= 4'h0;
            r_is_rd <= 1'b0;
            r_err   <= 1'b0;
            r_off   <= 8'h0;
        end else if (w_accept) begin
            r_wdata <= bus_wdata;
            r_wstrb <= bus_wstrb;
            r_is_rd <= w_is_rd;
            r_err   <= w_bad;
            if (!w_bad) r_off <= w_off;
        end
    end

    // Holding register for read data, sampled as RD_CAPTURE ends.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                     r_hold <= 32'h0;
        else if (r_state == RD_CAPTURE)  r_hold <= gpio_data_out;
    end

    // Write data is loaded on the edge entering WR_ISSUE and held afterwards.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_din <= 32'h0;
        else if (w_accept && !w_bad && w_full)
            r_din <= bus_wdata;
        else if ((r_state == RD_CAPTURE) && !r_is_rd)
            r_din <= w_merged;
    end

    // Outputs decoded from state; reset forces IDLE so all go low at once.
    always_comb begin
        gpio_en          = (r_state == RD_ISSUE) || (r_state == WR_ISSUE);
        gpio_wr          = (r_state == WR_ISSUE);
        gpio_addr_offset = r_off;
        gpio_data_in     = r_din;
        bus_ready        = (r_state == RESP);
        bus_err          = (r_state == RESP) && r_err;
        bus_rdata        = ((r_state == RESP) && r_is_rd && !r_err) ? r_hold : 32'h0;
    end

endmodule

// File: tb/tb_gpio_bus_bridge.sv
// Directed bench for gpio_bus_bridge with a small register-IP model.
module tb_gpio_bus_bridge;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        bus_valid = 1'b0;
    logic [31:0] bus_addr = 32'h0;
    logic [31:0] bus_wdata = 32'h0;
    logic [3:0]  bus_wstrb = 4'h0;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        bus_err;
    logic        gpio_en;
    logic        gpio_wr;
    logic [7:0]  gpio_addr_offset;
    logic [31:0] gpio_data_in;
    logic [31:0] gpio_data_out = 32'h0;

    int n_chk = 0;
    int n_fail = 0;

    gpio_bus_bridge #(.BASE_ADDR(BASE)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .bus_valid        (bus_valid),
        .bus_addr         (bus_addr),
        .bus_wdata        (bus_wdata),
        .bus_wstrb        (bus_wstrb),
        .bus_ready        (bus_ready),
        .bus_rdata        (bus_rdata),
        .bus_err          (bus_err),
        .gpio_en          (gpio_en),
        .gpio_wr          (gpio_wr),
        .gpio_addr_offset (gpio_addr_offset),
        .gpio_data_in     (gpio_data_in),
        .gpio_data_out    (gpio_data_out)
    );

    always #5 clk = ~clk;

    // Register IP model plus access monitor.
    logic [31:0] m_data = 32'hA5A5_1234;
    logic [31:0] m_dir  = 32'h0000_0000;
    int          en_cnt = 0;
    int          wr_cnt = 0;
    logic [7:0]  last_off = 8'h0;
    logic [31:0] last_din = 32'h0;

    always @(posedge clk) begin
        if (gpio_en) begin
            en_cnt   <= en_cnt + 1;
            last_off <= gpio_addr_offset;
            if (gpio_wr) begin
                wr_cnt   <= wr_cnt + 1;
                last_din <= gpio_data_in;
                if (gpio_addr_offset == 8'h00) m_data <= gpio_data_in;
                if (gpio_addr_offset == 8'h04) m_dir  <= gpio_data_in;
            end else begin
                case (gpio_addr_offset)
                    8'h00:   gpio_data_out <= m_data;
                    8'h04:   gpio_data_out <= m_dir;
                    8'h08:   gpio_data_out <= 32'hDEAD_BEEF;
                    default: gpio_data_out <= 32'h0;
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request; exp_lat is cycles from acceptance to bus_ready (0 = none).
    task automatic do_req(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int exp_lat, input logic exp_err,
                          input logic [31:0] exp_rdata, input int exp_en, input int exp_wr,
                          input logic [7:0] exp_off, input logic [31:0] exp_din);
        int en0, wr0, lat;
        logic [31:0] rd;
        logic er;
        lat = 0; rd = 32'h0; er = 1'b0;
        @(negedge clk);
        en0 = en_cnt; wr0 = wr_cnt;
        bus_valid = 1'b1; bus_addr = addr; bus_wdata = wdata; bus_wstrb = wstrb;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (bus_ready) begin
                lat = k; rd = bus_rdata; er = bus_err;
                break;
            end
            // Scramble captured fields mid-flight; the bridge must ignore them.
            if (k == 1 && exp_lat != 0) begin
                bus_wdata = 32'h5A5A_5A5A; bus_wstrb = ~wstrb;
            end
        end
        bus_valid = 1'b0;
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        if (exp_lat != 0) begin
            chk({tag, " err"}, {31'h0, er}, {31'h0, exp_err});
            chk({tag, " rdata"}, rd, exp_rdata);
            @(posedge clk); #1;
            chk({tag, " ready one cycle"}, {31'h0, bus_ready}, 32'h0);
        end
        chk({tag, " en pulses"}, 32'(en_cnt - en0), 32'(exp_en));
        chk({tag, " wr pulses"}, 32'(wr_cnt - wr0), 32'(exp_wr));
        if (exp_en != 0) chk({tag, " offset"}, {24'h0, last_off}, {24'h0, exp_off});
        if (exp_wr != 0) chk({tag, " data_in"}, last_din, exp_din);
    endtask

    initial begin
        int en0;
        logic seen;
        // Reset state
        #12;
        chk("rst ready", {31'h0, bus_ready}, 32'h0);
        chk("rst en",    {31'h0, gpio_en}, 32'h0);
        chk("rst off",   {24'h0, gpio_addr_offset}, 32'h0);
        chk("rst din",   gpio_data_in, 32'h0);
        chk("rst rdata", bus_rdata, 32'h0);
        @(negedge clk); resetn = 1'b1;

        // Full write to dir
        do_req("fullwr dir", BASE + 32'h04, 32'h0000_00FF, 4'hF, 2, 1'b0, 32'h0, 1, 1, 8'h04, 32'h0000_00FF);
        // Read of data register
        do_req("rd data", BASE, 32'h0, 4'h0, 3, 1'b0, 32'hA5A5_1234, 1, 0, 8'h00, 32'h0);
        // Set data register, then byte-0 partial write
        do_req("fullwr data", BASE, 32'h1122_3344, 4'hF, 2, 1'b0, 32'h0, 1, 1, 8'h00, 32'h1122_3344);
        do_req("partwr b0", BASE, 32'h0000_00CC, 4'h1, 4, 1'b0, 32'h0, 2, 1, 8'h00, 32'h1122_33CC);
        do_req("rd merged", BASE, 32'h0, 4'h0, 3, 1'b0, 32'h1122_33CC, 1, 0, 8'h00, 32'h0);
        // Input register read
        do_req("rd input", BASE + 32'h08, 32'h0, 4'h0, 3, 1'b0, 32'hDEAD_BEEF, 1, 0, 8'h08, 32'h0);
        // Middle-lanes partial write to dir (dir = 0x000000FF)
        do_req("partwr b12", BASE + 32'h04, 32'hAABB_CCDD, 4'h6, 4, 1'b0, 32'h0, 2, 1, 8'h04, 32'h00BB_CCFF);
        do_req("rd dir", BASE + 32'h04, 32'h0, 4'h0, 3, 1'b0, 32'h00BB_CCFF, 1, 0, 8'h04, 32'h0);
        // Error cases
        do_req("wr input", BASE + 32'h08, 32'hFFFF_FFFF, 4'hF, 1, 1'b1, 32'h0, 0, 0, 8'h0, 32'h0);
        do_req("rd illegal", BASE + 32'h0C, 32'h0, 4'h0, 1, 1'b1, 32'h0, 0, 0, 8'h0, 32'h0);
        do_req("rd misalign", BASE + 32'h02, 32'h0, 4'h0, 1, 1'b1, 32'h0, 0, 0, 8'h0, 32'h0);
        // Outside the window
        do_req("miss", 32'h0050_0000, 32'h0, 4'h0, 0, 1'b0, 32'h0, 0, 0, 8'h0, 32'h0);

        // Reset during RD_CAPTURE
        @(negedge clk);
        bus_valid = 1'b1; bus_addr = BASE + 32'h04; bus_wstrb = 4'h0;
        @(posedge clk); @(posedge clk); #2;
        en0 = en_cnt;
        resetn = 1'b0;
        #1;
        chk("abort ready", {31'h0, bus_ready}, 32'h0);
        chk("abort en",    {31'h0, gpio_en}, 32'h0);
        chk("abort wr",    {31'h0, gpio_wr}, 32'h0);
        chk("abort off",   {24'h0, gpio_addr_offset}, 32'h0);
        chk("abort din",   gpio_data_in, 32'h0);
        chk("abort rdata", bus_rdata, 32'h0);
        chk("abort err",   {31'h0, bus_err}, 32'h0);
        bus_valid = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus_ready) seen = 1'b1;
        end
        chk("abort no resp", {31'h0, seen}, 32'h0);
        chk("abort no en",   32'(en_cnt - en0), 32'h0);
        @(negedge clk); resetn = 1'b1;
        do_req("rd after rst", BASE + 32'h04, 32'h0, 4'h0, 3, 1'b0, 32'h00BB_CCFF, 1, 0, 8'h04, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
